udp_payload_aligner: RTL and testbench

//   Downstream neighbour of the UDP header decoder on the 64-bit frame datapath.

---
 rtl/udp_payload_aligner_pkg.sv | 22 ++
 rtl/udp_payload_aligner_if.sv | 23 ++
 rtl/udp_payload_aligner.sv | 144 ++++++++++++++
 tb/tb_udp_payload_aligner.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_payload_aligner_pkg.sv
// Shared constants, FSM state encoding and keep-mask helper for the UDP payload aligner.
package udp_payload_aligner_pkg;

  localparam logic [6:0]  PAYLOAD_BEAT  = 7'd5;
  localparam logic [15:0] UDP_HDR_BYTES = 16'd8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DROP   = 3'd4
  } state_t;

  // Contiguous byte mask of min(cap, n) bytes starting at bit 0.
  function automatic logic [7:0] keep_mask(input logic [15:0] n, input logic [3:0] cap);
    logic [3:0] m;
    m = (n > {12'd0, cap}) ? cap : n[3:0];
    return 8'hFF >> (4'd8 - m);
  endfunction

endpackage

// File: rtl/udp_payload_aligner_if.sv
// Frame-beat input bus plus aligned payload output bus of the UDP payload aligner.
interface udp_payload_aligner_if;
  logic [63:0] dataIn;
  logic        dataValid;
  logic [6:0]  counter;
  logic        lastIn;
  logic [15:0] length;
  logic [63:0] payloadOut;
  logic [7:0]  payloadKeep;
  logic        payloadValid;
  logic        payloadLast;
  logic        lengthErr;

  modport slave (
    input  dataIn, dataValid, counter, lastIn, length,
    output payloadOut, payloadKeep, payloadValid, payloadLast, lengthErr
  );

  modport master (
    output dataIn, dataValid, counter, lastIn, length,
    input  payloadOut, payloadKeep, payloadValid, payloadLast, lengthErr
  );
endinterface

// File: rtl/udp_payload_aligner.sv
// Strips Ethernet/IPv4/UDP headers and re-aligns the UDP payload to 64-bit words,
// trimming to the decoder's UDP length and flagging short or truncated datagrams.
module udp_payload_aligner
  import udp_payload_aligner_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  udp_payload_aligner_if.slave  bus
);

  state_t      state, state_nx;
  logic [31:0] hi_hold, hi_nx;
  logic [15:0] left, left_nx;
  logic        from_idle, from_idle_nx;

  logic [63:0] out_data, o_data;
  logic [7:0]  out_keep, o_keep;
  logic        out_vld, o_vld;
  logic        out_last, o_last;
  logic        out_err, o_err;

  logic [15:0] n, bl, bl_dec, r;
  logic        short_len, restart, hold_skip;

  assign n         = bus.length - UDP_HDR_BYTES;
  assign short_len = bus.length < UDP_HDR_BYTES;
  // HOLD streams with the freshly decoded length, STREAM with the running count.
  assign bl        = (state == HOLD) ? n : left;
  assign bl_dec    = (bl > 16'd8) ? (bl - 16'd8) : 16'd0;
  assign hold_skip = (state == HOLD) && (short_len || (n == 16'd0));
  assign r         = from_idle ? (short_len ? 16'd0 : n) : left;
  // A beat 0 outside IDLE means the previous frame was cut short.
  assign restart   = bus.dataValid && (bus.counter == 7'd0) &&
                     (state != IDLE) && (state != FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hi_hold   <= '0;
      left      <= '0;
      from_idle <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_vld   <= 1'b0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      hi_hold   <= hi_nx;
      left      <= left_nx;
      from_idle <= from_idle_nx;
      out_data  <= o_data;
      out_keep  <= o_keep;
      out_vld   <= o_vld;
      out_last  <= o_last;
      out_err   <= o_err;
    end
  end

  always_comb begin
    state_nx     = state;
    hi_nx        = hi_hold;
    left_nx      = left;
    from_idle_nx = from_idle;
    if (restart) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dataValid && (bus.counter == PAYLOAD_BEAT)) begin
            hi_nx        = bus.dataIn[63:32];
            from_idle_nx = 1'b1;
            state_nx     = bus.lastIn ? FLUSH : HOLD;
          end
        end
        HOLD, STREAM: begin
          if (bus.dataValid) begin
            if (hold_skip) begin
              state_nx = bus.lastIn ? IDLE : DROP;
            end else begin
              hi_nx   = bus.dataIn[63:32];
              left_nx = bl_dec;
              if (bl <= 16'd8) begin
                state_nx = bus.lastIn ? IDLE : DROP;
              end else if (bus.lastIn) begin
                state_nx     = FLUSH;
                from_idle_nx = 1'b0;
              end else begin
                state_nx = STREAM;
              end
            end
          end
        end
        FLUSH:   state_nx = IDLE;
        DROP:    if (bus.dataValid && bus.lastIn) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Data and keep hold their last emitted value whenever no word goes out.
  always_comb begin
    o_data = out_data;
    o_keep = out_keep;
    o_vld  = 1'b0;
    o_last = 1'b0;
    o_err  = 1'b0;
    if (restart) begin
      o_err = (state == HOLD) || (state == STREAM);
    end else begin
      case (state)
        HOLD, STREAM: begin
          if (bus.dataValid) begin
            if (state == HOLD && short_len) begin
              o_err = 1'b1;
            end else if (!hold_skip) begin
              o_vld  = 1'b1;
              o_data = {bus.dataIn[31:0], hi_hold};
              o_keep = keep_mask(bl, 4'd8);
              o_last = (bl <= 16'd8);
            end
          end
        end
        FLUSH: begin
          if (r != 16'd0) begin
            o_vld  = 1'b1;
            o_data = {32'h0, hi_hold};
            o_keep = keep_mask(r, 4'd4);
            o_last = 1'b1;
          end
          o_err = (r > 16'd4) || (from_idle && short_len);
        end
        default: ;
      endcase
    end
  end

  assign bus.payloadOut   = out_data;
  assign bus.payloadKeep  = out_keep;
  assign bus.payloadValid = out_vld;
  assign bus.payloadLast  = out_last;
  assign bus.lengthErr    = out_err;

endmodule

// File: tb/tb_udp_payload_aligner.sv
// Self-checking bench: byte-level payload model predicts every emitted word/error and its cycle.
module tb_udp_payload_aligner;

  typedef struct packed {
    int unsigned cyc;
    logic        vld;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        err;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  udp_payload_aligner_if bus();
  udp_payload_aligner dut (.clk(clk), .rst(rst), .bus(bus));

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t got[$];
  ev_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] bd[16];
  int unsigned bc[16];

  always @(negedge clk) begin
    ev_t e;
    if (!rst && (bus.payloadValid || bus.lengthErr || bus.payloadLast)) begin
      e.cyc  = cyc;
      e.vld  = bus.payloadValid;
      e.data = bus.payloadValid ? bus.payloadOut : 64'h0;
      e.keep = bus.payloadValid ? bus.payloadKeep : 8'h0;
      e.last = bus.payloadLast;
      e.err  = bus.lengthErr;
      got.push_back(e);
    end
  end

  // Payload byte i of the current frame: 4 bytes in beat 5's upper half, then 8 per beat.
  function automatic logic [7:0] pbyte(input int i);
    int j;
    if (i < 4) return bd[5][32 + 8*i +: 8];
    j = i - 4;
    return bd[6 + j/8][8*(j%8) +: 8];
  endfunction

  function automatic logic [7:0] mask(input int m);
    int v;
    v = (1 << m) - 1;
    return v[7:0];
  endfunction

  function automatic ev_t err_ev(input int unsigned c);
    ev_t e;
    e = '0;
    e.cyc = c;
    e.err = 1'b1;
    return e;
  endfunction

  // Expected events for a frame of beats 0..L; !ended means the next beat 0 follows at once.
  function automatic void model(input int L, input bit ended, input int len);
    ev_t e;
    int pl, words, avail, rem;
    if (L == 5 && ended) begin
      rem = (len < 8) ? 0 : len - 8;
      if (rem > 0) begin
        e = '0;
        e.cyc = bc[5] + 2; e.vld = 1'b1; e.last = 1'b1; e.err = (rem > 4);
        for (int b = 0; b < 4; b++) e.data[8*b +: 8] = pbyte(b);
        e.keep = mask(rem < 4 ? rem : 4);
        exp_q.push_back(e);
      end
      return;
    end
    if (L == 5) begin exp_q.push_back(err_ev(bc[5] + 2)); return; end
    if (len < 8) begin exp_q.push_back(err_ev(bc[6] + 1)); return; end
    pl = len - 8;
    if (pl == 0) return;
    words = (pl + 7) / 8;
    avail = L - 5;
    for (int k = 0; k < words && k < avail; k++) begin
      rem = pl - 8*k;
      e = '0;
      e.cyc = bc[6 + k] + 1; e.vld = 1'b1; e.last = (rem <= 8);
      for (int b = 0; b < 8; b++) e.data[8*b +: 8] = pbyte(8*k + b);
      e.keep = mask(rem < 8 ? rem : 8);
      exp_q.push_back(e);
    end
    if (words > avail) begin
      if (!ended) begin exp_q.push_back(err_ev(bc[L] + 2)); return; end
      rem = pl - 8*avail;
      e = '0;
      e.cyc = bc[L] + 2; e.vld = 1'b1; e.last = 1'b1; e.err = (rem > 4);
      for (int b = 0; b < 4; b++) e.data[8*b +: 8] = pbyte(8*avail + b);
      e.keep = mask(rem < 4 ? rem : 4);
      exp_q.push_back(e);
    end
  endfunction

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      bus.dataValid = 1'b0;
      bus.dataIn    = {$urandom, $urandom};
      bus.counter   = 7'($urandom);
      bus.lastIn    = 1'($urandom);
    end
  endtask

  task automatic drive_beat(input int c, input bit last);
    @(posedge clk); #1;
    bd[c] = {$urandom, $urandom};
    bc[c] = cyc;
    bus.dataValid = 1'b1;
    bus.dataIn    = bd[c];
    bus.counter   = 7'(c);
    bus.lastIn    = last;
  endtask

  task automatic send_frame(input int L, input bit ended, input int len, input int gfix, input bit grand);
    bus.length = 16'(len);
    for (int c = 0; c <= L; c++) begin
      if (c > 0) idle((c >= 6 ? gfix : 0) + (grand ? int'($urandom_range(0, 2)) : 0));
      drive_beat(c, ended && (c == L));
    end
    model(L, ended, len);
    if (ended) idle(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    n_cmp++; if (bus.payloadValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b expected 0", bus.payloadValid); end
    n_cmp++; if (bus.payloadLast !== 1'b0) begin n_bad++; $display("FAIL reset_last got %b expected 0", bus.payloadLast); end
    n_cmp++; if (bus.lengthErr !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b expected 0", bus.lengthErr); end
    n_cmp++; if (bus.payloadOut !== 64'h0) begin n_bad++; $display("FAIL reset_data got %h expected 0", bus.payloadOut); end
    n_cmp++; if (bus.payloadKeep !== 8'h0) begin n_bad++; $display("FAIL reset_keep got %h expected 0", bus.payloadKeep); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    got.delete(); exp_q.delete();
    send_frame(7, 1, 16, 0, 0);
    send_frame(7, 1, 21, 0, 0);
    send_frame(7, 1, 8, 0, 0);
    send_frame(7, 1, 5, 0, 0);
    send_frame(6, 1, 40, 0, 0);
    send_frame(5, 1, 14, 0, 0);
    idle(4);
    n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL directed_count got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL directed_ev%0d got cyc=%0d v=%b d=%h k=%h l=%b e=%b expected cyc=%0d v=%b d=%h k=%h l=%b e=%b", i,
                 got[i].cyc, got[i].vld, got[i].data, got[i].keep, got[i].last, got[i].err,
                 exp_q[i].cyc, exp_q[i].vld, exp_q[i].data, exp_q[i].keep, exp_q[i].last, exp_q[i].err);
      end
    end
  endtask

  task automatic test_gaps();
    got.delete(); exp_q.delete();
    send_frame(7, 1, 21, 2, 0);
    send_frame(9, 1, 40, 1, 1);
    idle(4);
    n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL gaps_count got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL gaps_ev%0d got cyc=%0d v=%b d=%h k=%h l=%b e=%b expected cyc=%0d v=%b d=%h k=%h l=%b e=%b", i,
                 got[i].cyc, got[i].vld, got[i].data, got[i].keep, got[i].last, got[i].err,
                 exp_q[i].cyc, exp_q[i].vld, exp_q[i].data, exp_q[i].keep, exp_q[i].last, exp_q[i].err);
      end
    end
  endtask

  task automatic test_reset_midframe();
    got.delete(); exp_q.delete();
    bus.length = 16'd40;
    for (int c = 0; c <= 5; c++) drive_beat(c, 1'b0);
    drive_beat(6, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.payloadValid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b expected 0", bus.payloadValid); end
    n_cmp++; if (bus.payloadOut !== 64'h0) begin n_bad++; $display("FAIL midrst_data got %h expected 0", bus.payloadOut); end
    send_frame(7, 1, 16, 0, 0);
    idle(4);
    n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL midrst_count got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL midrst_ev%0d got cyc=%0d v=%b d=%h k=%h l=%b e=%b expected cyc=%0d v=%b d=%h k=%h l=%b e=%b", i,
                 got[i].cyc, got[i].vld, got[i].data, got[i].keep, got[i].last, got[i].err,
                 exp_q[i].cyc, exp_q[i].vld, exp_q[i].data, exp_q[i].keep, exp_q[i].last, exp_q[i].err);
      end
    end
  endtask

  task automatic test_restart();
    got.delete(); exp_q.delete();
    send_frame(7, 0, 40, 0, 0);
    send_frame(7, 1, 16, 0, 0);
    idle(4);
    n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL restart_count got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL restart_ev%0d got cyc=%0d v=%b d=%h k=%h l=%b e=%b expected cyc=%0d v=%b d=%h k=%h l=%b e=%b", i,
                 got[i].cyc, got[i].vld, got[i].data, got[i].keep, got[i].last, got[i].err,
                 exp_q[i].cyc, exp_q[i].vld, exp_q[i].data, exp_q[i].keep, exp_q[i].last, exp_q[i].err);
      end
    end
  endtask

  task automatic test_random();
    int L, len;
    got.delete(); exp_q.delete();
    for (int f = 0; f < 30; f++) begin
      L   = int'($urandom_range(5, 12));
      len = int'($urandom_range(0, 80));
      if (L == 5 && len < 8) len = len + 8;
      send_frame(L, 1, len, 0, 1);
    end
    idle(4);
    n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL random_count got %0d expected %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL random_ev%0d got cyc=%0d v=%b d=%h k=%h l=%b e=%b expected cyc=%0d v=%b d=%h k=%h l=%b e=%b", i,
                 got[i].cyc, got[i].vld, got[i].data, got[i].keep, got[i].last, got[i].err,
                 exp_q[i].cyc, exp_q[i].vld, exp_q[i].data, exp_q[i].keep, exp_q[i].last, exp_q[i].err);
      end
    end
  endtask

  initial begin
    bus.dataValid = 1'b0;
    bus.dataIn    = '0;
    bus.counter   = '0;
    bus.lastIn    = 1'b0;
    bus.length    = '0;
    test_reset();
    test_directed();
    test_gaps();
    test_reset_midframe();
    test_restart();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
